iccm_arbiter: RTL



---
 rtl/iccm_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/iccm_arbiter.sv
// Arbitrates the single-port ICCM between instruction fetch and the host/loader bus,
// holding fetch off until boot completes and bounding fetch starvation afterwards.
module iccm_arbiter #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_STALL  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    boot_done_i,
  output logic                    fetch_en_o,
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  output logic                    if_gnt_o,
  output logic                    if_rvalid_o,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  input  logic                    hb_req_i,
  input  logic                    hb_we_i,
  input  logic [DATA_WIDTH/8-1:0] hb_wmask_i,
  input  logic [ADDR_WIDTH-1:0]   hb_addr_i,
  input  logic [DATA_WIDTH-1:0]   hb_wdata_i,
  output logic                    hb_gnt_o,
  output logic                    hb_rvalid_o,
  output logic [DATA_WIDTH-1:0]   hb_rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_wmask_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic                    mem_rvalid_i
);

  localparam logic [3:0] StallMax = 4'(MAX_STALL);

  typedef enum logic {BOOT, RUN} state_e;
  typedef enum logic [1:0] {RD_NONE, RD_FETCH, RD_HOST} owner_e;

  state_e     state_q;
  owner_e     rd_owner_q;
  logic [3:0] stall_cnt_q;
  logic       both_req;

  assign both_req = if_req_i & hb_req_i;

  // Grants are held low while reset is asserted so nothing reaches the memory.
  always_comb begin
    if_gnt_o = 1'b0;
    hb_gnt_o = 1'b0;
    if (rst_ni) begin
      if (state_q == BOOT) begin
        hb_gnt_o = hb_req_i;
      end else if (both_req) begin
        if (stall_cnt_q >= StallMax) if_gnt_o = 1'b1;
        else                         hb_gnt_o = 1'b1;
      end else begin
        if_gnt_o = if_req_i;
        hb_gnt_o = hb_req_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= BOOT;
      fetch_en_o  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      case (state_q)
        BOOT: begin
          stall_cnt_q <= '0;
          if (boot_done_i) begin
            state_q    <= RUN;
            fetch_en_o <= 1'b1;
          end
        end
        RUN: begin
          if (both_req && !if_gnt_o) stall_cnt_q <= stall_cnt_q + 4'd1;
          else                       stall_cnt_q <= '0;
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  always_comb begin
    mem_req_o   = if_gnt_o | hb_gnt_o;
    mem_we_o    = 1'b0;
    mem_wmask_o = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (hb_gnt_o) begin
      mem_we_o    = hb_we_i;
      mem_wmask_o = hb_wmask_i;
      mem_addr_o  = hb_addr_i;
      mem_wdata_o = hb_wdata_i;
    end else if (if_gnt_o) begin
      mem_addr_o  = if_addr_i;
    end
  end

  // Remember who issued the read so the one-cycle-later response finds its way home.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_owner_q <= RD_NONE;
    end else if (if_gnt_o) begin
      rd_owner_q <= RD_FETCH;
    end else if (hb_gnt_o && !hb_we_i) begin
      rd_owner_q <= RD_HOST;
    end else begin
      rd_owner_q <= RD_NONE;
    end
  end

  assign if_rvalid_o = mem_rvalid_i & (rd_owner_q == RD_FETCH);
  assign hb_rvalid_o = mem_rvalid_i & (rd_owner_q == RD_HOST);
  assign if_rdata_o  = mem_rdata_i;
  assign hb_rdata_o  = mem_rdata_i;

  err_drop: assert property (@(posedge clk_i) disable iff (!rst_ni)
                             !(mem_rvalid_i && rd_owner_q == RD_NONE));

endmodule
